// File: rtl/audio_echo.sv
// rtl/audio_echo.sv - stereo echo/delay stage with circular sample buffer; AUDIO_ECHO_FEEDBACK_EN selects repeating echoes
module audio_echo #(
    parameter int DATA_BITS = 24,
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_l,
    input  logic [DATA_BITS-1:0] in_r,
    input  logic [ADDR_BITS-1:0] delay_len,
    input  logic [2:0]           mix_shift,
    output logic                 out_valid,
    output logic [DATA_BITS-1:0] out_l,
    output logic [DATA_BITS-1:0] out_r,
    output logic                 busy,
    output logic                 drop
);
    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam int WORD_BITS = 2 * DATA_BITS;
    localparam logic [ADDR_BITS:0] FILL_MAX = (ADDR_BITS + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD, MIX, WR} state_t;

    state_t                 state_q, state_d;
    logic [DATA_BITS-1:0]   cap_l_q, cap_l_d, cap_r_q, cap_r_d;
    logic [ADDR_BITS-1:0]   cap_delay_q, cap_delay_d;
    logic [2:0]             cap_shift_q, cap_shift_d;
    logic [ADDR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS:0]     filled_q, filled_d;
    logic                   echo_en_q, echo_en_d;
    logic [DATA_BITS-1:0]   out_l_q, out_l_d, out_r_q, out_r_d;
    logic                   out_valid_q, out_valid_d;
    logic                   busy_q, busy_d;
    logic                   drop_q, drop_d;

    logic [WORD_BITS-1:0]   mem [DEPTH];
    logic [WORD_BITS-1:0]   rd_data_q;
    logic [ADDR_BITS-1:0]   rd_addr;
    logic                   wr_en;
    logic [WORD_BITS-1:0]   wr_data;
    logic [DATA_BITS-1:0]   dly_l, dly_r;

    function automatic logic [DATA_BITS-1:0] mix_sat(input logic [DATA_BITS-1:0] a,
                                                     input logic [DATA_BITS-1:0] d,
                                                     input logic [2:0]           sh);
        logic signed [DATA_BITS:0] ae, de, s;
        ae = {a[DATA_BITS-1], a};
        de = $signed({d[DATA_BITS-1], d}) >>> sh;
        s  = ae + de;
        if (s[DATA_BITS] != s[DATA_BITS-1])
            return s[DATA_BITS] ? {1'b1, {(DATA_BITS-1){1'b0}}} : {1'b0, {(DATA_BITS-1){1'b1}}};
        return s[DATA_BITS-1:0];
    endfunction

    assign rd_addr = wr_ptr_q - cap_delay_q;
    assign dly_l   = echo_en_q ? rd_data_q[WORD_BITS-1:DATA_BITS] : '0;
    assign dly_r   = echo_en_q ? rd_data_q[DATA_BITS-1:0]         : '0;
    // A reset landing on the WR edge abandons the sample, so the write is gated too.
    assign wr_en   = (state_q == WR) && rst_n;
`ifdef AUDIO_ECHO_FEEDBACK_EN
    assign wr_data = {out_l_q, out_r_q};
`else
    assign wr_data = {cap_l_q, cap_r_q};
`endif

    always_comb begin
        state_d     = state_q;
        cap_l_d     = cap_l_q;
        cap_r_d     = cap_r_q;
        cap_delay_d = cap_delay_q;
        cap_shift_d = cap_shift_q;
        wr_ptr_d    = wr_ptr_q;
        filled_d    = filled_q;
        echo_en_d   = echo_en_q;
        out_l_d     = out_l_q;
        out_r_d     = out_r_q;
        drop_d      = in_valid && (state_q != IDLE);
        case (state_q)
            IDLE: if (in_valid) begin
                state_d     = RD;
                cap_l_d     = in_l;
                cap_r_d     = in_r;
                cap_delay_d = delay_len;
                cap_shift_d = mix_shift;
            end
            RD: begin
                state_d   = MIX;
                echo_en_d = (cap_delay_q != '0) && ({1'b0, cap_delay_q} <= filled_q);
            end
            MIX: begin
                state_d = WR;
                out_l_d = mix_sat(cap_l_q, dly_l, cap_shift_q);
                out_r_d = mix_sat(cap_r_q, dly_r, cap_shift_q);
            end
            WR: begin
                state_d  = IDLE;
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (filled_q != FILL_MAX)
                    filled_d = filled_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        busy_d      = (state_d != IDLE);
        out_valid_d = (state_d == WR);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cap_l_q     <= '0;
            cap_r_q     <= '0;
            cap_delay_q <= '0;
            cap_shift_q <= '0;
            wr_ptr_q    <= '0;
            filled_q    <= '0;
            echo_en_q   <= 1'b0;
            out_l_q     <= '0;
            out_r_q     <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cap_l_q     <= cap_l_d;
            cap_r_q     <= cap_r_d;
            cap_delay_q <= cap_delay_d;
            cap_shift_q <= cap_shift_d;
            wr_ptr_q    <= wr_ptr_d;
            filled_q    <= filled_d;
            echo_en_q   <= echo_en_d;
            out_l_q     <= out_l_d;
            out_r_q     <= out_r_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            drop_q      <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == RD)
            rd_data_q <= mem[rd_addr];
        if (wr_en)
            mem[wr_ptr_q] <= wr_data;
    end

    assign out_valid = out_valid_q;
    assign out_l     = out_l_q;
    assign out_r     = out_r_q;
    assign busy      = busy_q;
    assign drop      = drop_q;
endmodule

// File: tb/tb_audio_echo.sv
// tb/tb_audio_echo.sv - randomized self-checking bench for audio_echo against a sample-history model
module tb_audio_echo;
    localparam int DB = 24;
    localparam int AB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DB-1:0] in_l, in_r;
    logic [AB-1:0] delay_len;
    logic [2:0]    mix_shift;
    logic          out_valid;
    logic [DB-1:0] out_l, out_r;
    logic          busy, drop;

    int vectors = 0;
    int miscompares = 0;

    longint hist_l[$];
    longint hist_r[$];
    longint exp_q[$];
    longint imp[10];
    longint got_l, got_r;

    audio_echo #(.DATA_BITS(DB), .ADDR_BITS(AB)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_l(in_l), .in_r(in_r),
        .delay_len(delay_len), .mix_shift(mix_shift), .out_valid(out_valid),
        .out_l(out_l), .out_r(out_r), .busy(busy), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > 64'sd8388607)  return 64'sd8388607;
        if (v < -64'sd8388608) return -64'sd8388608;
        return v;
    endfunction

    function automatic longint sx(input logic [DB-1:0] v);
        return longint'($signed(v));
    endfunction

    // Each written word is remembered in order; the echo is the word written dl samples ago.
    task automatic model_step(input logic [DB-1:0] l, input logic [DB-1:0] r, input int dl,
                              input int sh, output longint el, output longint er);
        longint dlv, drv;
        int n;
        n = hist_l.size();
        dlv = 0;
        drv = 0;
        if (dl != 0 && dl <= n) begin
            dlv = hist_l[n-dl];
            drv = hist_r[n-dl];
        end
        el = sat(sx(l) + (dlv >>> sh));
        er = sat(sx(r) + (drv >>> sh));
`ifdef AUDIO_ECHO_FEEDBACK_EN
        hist_l.push_back(el);
        hist_r.push_back(er);
`else
        hist_l.push_back(sx(l));
        hist_r.push_back(sx(r));
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist_l.delete();
        hist_r.delete();
    endtask

    task automatic send(input logic [DB-1:0] l, input logic [DB-1:0] r, input int dl,
                        input int sh, output longint ol, output longint orr);
        longint el, er;
        int n;
        in_l = l; in_r = r; delay_len = AB'(dl); mix_shift = 3'(sh); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        delay_len = AB'($urandom);
        mix_shift = 3'($urandom);
        model_step(l, r, dl, sh, el, er);
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk); #1;
            n++;
        end
        chk("out_valid_timeout", longint'(out_valid), 1);
        chk("lat", n, 2);
        ol = sx(out_l);
        orr = sx(out_r);
        chk("out_l", ol, el);
        chk("out_r", orr, er);
        @(posedge clk); #1;
        chk("busy_idle", longint'(busy), 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_l = '0; in_r = '0; delay_len = '0; mix_shift = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_l", sx(out_l), 0);
        chk("rst_out_r", sx(out_r), 0);
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_busy", longint'(busy), 0);
        chk("rst_drop", longint'(drop), 0);
        rst_n = 1'b1;

        do_reset();
        for (int i = 0; i < 10; i++) begin
            send((i == 0) ? 24'h100000 : 24'h0, 24'h0, 3, 1, imp[i], got_r);
            chk("imp_r", got_r, 0);
        end
        chk("imp_s0", imp[0], 64'h100000);
        chk("imp_s3", imp[3], 64'h080000);
        chk("imp_s1", imp[1], 0);
`ifdef AUDIO_ECHO_FEEDBACK_EN
        chk("imp_s6", imp[6], 64'h040000);
        chk("imp_s9", imp[9], 64'h020000);
`else
        chk("imp_s6", imp[6], 0);
        chk("imp_s9", imp[9], 0);
`endif

        do_reset();
        send(24'h7FFFFF, 24'h7FFFFF, 1, 0, got_l, got_r);
        send(24'h7FFFFF, 24'h7FFFFF, 1, 0, got_l, got_r);
        chk("sat_pos", got_l, 64'sd8388607);
        do_reset();
        send(24'h800000, 24'h800000, 1, 0, got_l, got_r);
        send(24'h800000, 24'h800000, 1, 0, got_l, got_r);
        chk("sat_neg", got_r, -64'sd8388608);

        do_reset();
        for (int n = 1; n <= 40; n++) begin
            send(DB'(n), DB'(100 + n), 15, 0, got_l, got_r);
`ifndef AUDIO_ECHO_FEEDBACK_EN
            chk("ramp", got_l, (n <= 15) ? longint'(n) : longint'(2 * n - 15));
`endif
        end

        do_reset();
        for (int i = 0; i < 80; i++)
            send(DB'($urandom), DB'($urandom), int'($urandom_range(0, 15)),
                 int'($urandom_range(0, 7)), got_l, got_r);

        do_reset();
        begin
            longint el, er;
            in_l = 24'h000123; in_r = 24'h000456; delay_len = '0; mix_shift = '0; in_valid = 1'b1;
            model_step(in_l, in_r, 0, 0, el, er);
            exp_q.push_back(el);
            for (int k = 1; k <= 10; k++) begin
                @(posedge clk); #1;
                chk("hs_busy", longint'(busy), longint'(k inside {1, 2, 3, 5, 6, 7}));
                chk("hs_out_valid", longint'(out_valid), longint'(k == 3 || k == 7));
                chk("hs_drop", longint'(drop), longint'(k == 3));
                if (out_valid && exp_q.size() > 0)
                    chk("hs_out_l", sx(out_l), exp_q.pop_front());
                in_valid = (k == 2 || k == 4);
                if (k == 2) in_l = 24'h0DEAD0;
                if (k == 4) begin
                    in_l = 24'h000777;
                    model_step(in_l, in_r, 0, 0, el, er);
                    exp_q.push_back(el);
                end
            end
            chk("hs_pending", exp_q.size(), 0);
        end

        do_reset();
        delay_len = AB'(1); mix_shift = '0; in_l = 24'h100000; in_r = '0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("mr_ov_rd", longint'(out_valid), 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hist_l.delete();
        hist_r.delete();
        for (int k = 0; k < 4; k++) begin
            chk("mr_no_ov", longint'(out_valid), 0);
            @(posedge clk); #1;
        end
        chk("mr_out_l", sx(out_l), 0);
        chk("mr_out_r", sx(out_r), 0);
        chk("mr_busy", longint'(busy), 0);
        chk("mr_drop", longint'(drop), 0);
        send(24'h000010, 24'h0, 1, 0, got_l, got_r);
        chk("mr_next", got_l, 64'h10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
